// File: rtl/vend_controller.sv
// vend_controller: top-level vending machine sequencer.
//
// Accumulates credit from one-hot money events, arbitrates product selection
// against price and per-product stock, pulses dispense for one cycle and then
// returns change one coin per cycle using the greedy denominations
// 5000 > 2000 > 1000 > 500. All outputs are registered.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   money_type     in   [3:0] one-hot coin event (0001=500 .. 1000=5000), 0000 none
//   select_valid   in   product selection strobe
//   product_sel    in   [1:0] product index, sampled with select_valid
//   cancel         in   refund request
//   credit         out  [15:0] current credit
//   busy           out  high while in DISPENSE or CHANGE
//   dispense_valid out  one-cycle dispense pulse
//   dispense_id    out  [1:0] product being dispensed
//   change_valid   out  one change coin returned this cycle
//   change_type    out  [3:0] denomination of the returned coin (one-hot)
//   coin_reject    out  one-cycle pulse, inserted coin refused
//   error          out  [3:0] sticky error: 0001 invalid money, 0010 insufficient
//                       credit, 0100 out of stock, 1000 credit limit
module vend_controller #(
  parameter logic [15:0] PRICE0     = 16'd1500,
  parameter logic [15:0] PRICE1     = 16'd2500,
  parameter logic [15:0] PRICE2     = 16'd3000,
  parameter logic [15:0] PRICE3     = 16'd6000,
  parameter logic [7:0]  STOCK_INIT = 8'd5,
  parameter logic [15:0] MAX_CREDIT = 16'd20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  money_type,
  input  logic        select_valid,
  input  logic [1:0]  product_sel,
  input  logic        cancel,
  output logic [15:0] credit,
  output logic        busy,
  output logic        dispense_valid,
  output logic [1:0]  dispense_id,
  output logic        change_valid,
  output logic [3:0]  change_type,
  output logic        coin_reject,
  output logic [3:0]  error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0][7:0] stock;
  logic [3:0][7:0] stock_nxt;
  logic [15:0]     credit_nxt;
  logic [3:0]      error_nxt;
  logic            busy_nxt;
  logic            dispense_valid_nxt;
  logic [1:0]      dispense_id_nxt;
  logic            change_valid_nxt;
  logic [3:0]      change_type_nxt;
  logic            coin_reject_nxt;

  logic [15:0]     coin_val;
  logic            coin_bad;
  logic [16:0]     coin_sum;
  logic [3:0]      chg_type;
  logic [15:0]     chg_val;
  logic [15:0]     price;

  // Value of a one-hot coin code; zero for no event or an invalid code.
  function automatic logic [15:0] coin_value(input logic [3:0] m);
    case (m)
      4'b0001: coin_value = 16'd500;
      4'b0010: coin_value = 16'd1000;
      4'b0100: coin_value = 16'd2000;
      4'b1000: coin_value = 16'd5000;
      default: coin_value = 16'd0;
    endcase
  endfunction

  // Largest denomination not exceeding the given credit.
  function automatic logic [3:0] greedy_coin(input logic [15:0] c);
    if (c >= 16'd5000)      greedy_coin = 4'b1000;
    else if (c >= 16'd2000) greedy_coin = 4'b0100;
    else if (c >= 16'd1000) greedy_coin = 4'b0010;
    else if (c >= 16'd500)  greedy_coin = 4'b0001;
    else                    greedy_coin = 4'b0000;
  endfunction

  function automatic logic [15:0] price_of(input logic [1:0] p);
    case (p)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt          = state;
    credit_nxt         = credit;
    stock_nxt          = stock;
    error_nxt          = error;
    dispense_valid_nxt = 1'b0;
    dispense_id_nxt    = dispense_id;
    change_valid_nxt   = 1'b0;
    change_type_nxt    = 4'b0000;
    coin_reject_nxt    = 1'b0;

    coin_val = coin_value(money_type);
    coin_bad = (money_type != 4'b0000) && (coin_val == 16'd0);
    coin_sum = {1'b0, credit} + {1'b0, coin_val};
    chg_type = greedy_coin(credit);
    chg_val  = coin_value(chg_type);
    price    = price_of(product_sel);

    case (state)
      IDLE, COLLECT: begin
        if (cancel && (state == COLLECT) && (credit != 16'd0)) begin
          // Refund starts immediately: the first coin goes out with the entry into CHANGE.
          coin_reject_nxt  = (money_type != 4'b0000);
          state_nxt        = CHANGE;
          change_valid_nxt = 1'b1;
          change_type_nxt  = chg_type;
          credit_nxt       = credit - chg_val;
        end else if (select_valid) begin
          coin_reject_nxt = (money_type != 4'b0000);
          if (stock[product_sel] == 8'd0) begin
            error_nxt = 4'b0100;
          end else if (credit < price) begin
            error_nxt = 4'b0010;
          end else begin
            credit_nxt               = credit - price;
            stock_nxt[product_sel]   = stock[product_sel] - 8'd1;
            error_nxt                = 4'b0000;
            state_nxt                = DISPENSE;
            dispense_valid_nxt       = 1'b1;
            dispense_id_nxt          = product_sel;
          end
        end else if (cancel) begin
          // Ineffective cancel still claims the cycle, so any coin is refused.
          coin_reject_nxt = (money_type != 4'b0000);
        end else if (coin_bad) begin
          coin_reject_nxt = 1'b1;
          error_nxt       = 4'b0001;
        end else if (coin_val != 16'd0) begin
          if (coin_sum <= {1'b0, MAX_CREDIT}) begin
            credit_nxt = coin_sum[15:0];
            error_nxt  = 4'b0000;
            state_nxt  = COLLECT;
          end else begin
            coin_reject_nxt = 1'b1;
            error_nxt       = 4'b1000;
          end
        end else begin
          state_nxt = state;
        end
      end
      DISPENSE, CHANGE: begin
        coin_reject_nxt = (money_type != 4'b0000);
        if (credit != 16'd0) begin
          state_nxt        = CHANGE;
          change_valid_nxt = 1'b1;
          change_type_nxt  = chg_type;
          credit_nxt       = credit - chg_val;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == DISPENSE) || (state_nxt == CHANGE);
  end

  // Registered datapath and outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credit         <= 16'd0;
      stock          <= {4{STOCK_INIT}};
      error          <= 4'b0000;
      busy           <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_id    <= 2'd0;
      change_valid   <= 1'b0;
      change_type    <= 4'b0000;
      coin_reject    <= 1'b0;
    end else begin
      credit         <= credit_nxt;
      stock          <= stock_nxt;
      error          <= error_nxt;
      busy           <= busy_nxt;
      dispense_valid <= dispense_valid_nxt;
      dispense_id    <= dispense_id_nxt;
      change_valid   <= change_valid_nxt;
      change_type    <= change_type_nxt;
      coin_reject    <= coin_reject_nxt;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed self-checking bench for vend_controller.
module tb_vend_controller;

  logic        clock;
  logic        reset;
  logic [3:0]  money_type;
  logic        select_valid;
  logic [1:0]  product_sel;
  logic        cancel;
  logic [15:0] credit;
  logic        busy;
  logic        dispense_valid;
  logic [1:0]  dispense_id;
  logic        change_valid;
  logic [3:0]  change_type;
  logic        coin_reject;
  logic [3:0]  error;

  int checks = 0;
  int errors = 0;

  vend_controller dut (
    .clock          (clock),
    .reset          (reset),
    .money_type     (money_type),
    .select_valid   (select_valid),
    .product_sel    (product_sel),
    .cancel         (cancel),
    .credit         (credit),
    .busy           (busy),
    .dispense_valid (dispense_valid),
    .dispense_id    (dispense_id),
    .change_valid   (change_valid),
    .change_type    (change_type),
    .coin_reject    (coin_reject),
    .error          (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic insert(input logic [3:0] m);
    money_type = m;
    cyc();
    money_type = 4'b0000;
  endtask

  task automatic choose(input logic [1:0] p);
    select_valid = 1'b1;
    product_sel  = p;
    cyc();
    select_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (credit !== 16'd0) begin errors++; $display("FAIL reset_credit got %0d exp 0", credit); end
    checks++; if (error !== 4'b0000) begin errors++; $display("FAIL reset_error got %b exp 0000", error); end
    checks++; if ({busy, dispense_valid, change_valid, coin_reject} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {busy, dispense_valid, change_valid, coin_reject}); end
    checks++; if ({change_type, dispense_id} !== 6'b0) begin errors++; $display("FAIL reset_ids got %b exp 000000", {change_type, dispense_id}); end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic_purchase();
    insert(4'b0010);
    checks++; if (credit !== 16'd1000) begin errors++; $display("FAIL basic_credit1 got %0d exp 1000", credit); end
    insert(4'b0010);
    checks++; if (credit !== 16'd2000) begin errors++; $display("FAIL basic_credit2 got %0d exp 2000", credit); end
    choose(2'd0);
    checks++; if ({dispense_valid, dispense_id, busy} !== 4'b1001) begin errors++; $display("FAIL basic_dispense got %b exp 1001", {dispense_valid, dispense_id, busy}); end
    checks++; if (credit !== 16'd500) begin errors++; $display("FAIL basic_credit3 got %0d exp 500", credit); end
    cyc();
    checks++; if ({dispense_valid, change_valid, change_type} !== 6'b010001) begin errors++; $display("FAIL basic_change got %b exp 010001", {dispense_valid, change_valid, change_type}); end
    cyc();
    checks++; if ({change_valid, busy, credit} !== 18'd0) begin errors++; $display("FAIL basic_idle got cv=%b busy=%b credit=%0d exp 0 0 0", change_valid, busy, credit); end
  endtask

  task automatic test_change_sequence();
    logic [3:0] exp_types [3] = '{4'b0100, 4'b0100, 4'b0001};
    insert(4'b1000);
    insert(4'b0100);
    checks++; if (credit !== 16'd7000) begin errors++; $display("FAIL seq_credit got %0d exp 7000", credit); end
    choose(2'd1);
    checks++; if ({dispense_valid, dispense_id, credit} !== {1'b1, 2'd1, 16'd4500}) begin errors++; $display("FAIL seq_dispense got dv=%b id=%0d credit=%0d exp 1 1 4500", dispense_valid, dispense_id, credit); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if ({change_valid, busy, change_type} !== {2'b11, exp_types[i]}) begin errors++; $display("FAIL seq_coin%0d got cv=%b busy=%b type=%b exp 1 1 %b", i, change_valid, busy, change_type, exp_types[i]); end
    end
    cyc();
    checks++; if ({change_valid, busy, credit} !== 18'd0) begin errors++; $display("FAIL seq_idle got cv=%b busy=%b credit=%0d exp 0 0 0", change_valid, busy, credit); end
  endtask

  task automatic test_insufficient();
    insert(4'b0001);
    choose(2'd3);
    checks++; if ({error, dispense_valid, credit} !== {4'b0010, 1'b0, 16'd500}) begin errors++; $display("FAIL insuf_err got err=%b dv=%b credit=%0d exp 0010 0 500", error, dispense_valid, credit); end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    checks++; if ({change_valid, change_type, credit} !== {1'b1, 4'b0001, 16'd0}) begin errors++; $display("FAIL insuf_refund got cv=%b type=%b credit=%0d exp 1 0001 0", change_valid, change_type, credit); end
    cyc();
    checks++; if ({change_valid, busy} !== 2'b00) begin errors++; $display("FAIL insuf_idle got %b exp 00", {change_valid, busy}); end
  endtask

  task automatic test_out_of_stock();
    for (int i = 0; i < 5; i++) begin
      insert(4'b0100);
      insert(4'b0010);
      choose(2'd2);
      checks++; if ({dispense_valid, dispense_id, credit} !== {1'b1, 2'd2, 16'd0}) begin errors++; $display("FAIL stock_buy%0d got dv=%b id=%0d credit=%0d exp 1 2 0", i, dispense_valid, dispense_id, credit); end
      cyc();
    end
    insert(4'b0100);
    insert(4'b0010);
    choose(2'd2);
    checks++; if ({error, dispense_valid, credit} !== {4'b0100, 1'b0, 16'd3000}) begin errors++; $display("FAIL stock_empty got err=%b dv=%b credit=%0d exp 0100 0 3000", error, dispense_valid, credit); end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    cyc();
    cyc();
    checks++; if ({busy, credit} !== 17'd0) begin errors++; $display("FAIL stock_drain got busy=%b credit=%0d exp 0 0", busy, credit); end
  endtask

  task automatic test_invalid_money();
    insert(4'b0011);
    checks++; if ({error, coin_reject, credit} !== {4'b0001, 1'b1, 16'd0}) begin errors++; $display("FAIL inv_code got err=%b rej=%b credit=%0d exp 0001 1 0", error, coin_reject, credit); end
    cyc();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL inv_pulse got %b exp 0", coin_reject); end
    money_type = 4'b0010;
    choose(2'd0);
    money_type = 4'b0000;
    checks++; if ({coin_reject, credit} !== {1'b1, 16'd0}) begin errors++; $display("FAIL inv_with_select got rej=%b credit=%0d exp 1 0", coin_reject, credit); end
    for (int i = 0; i < 4; i++) insert(4'b1000);
    checks++; if ({error, credit} !== {4'b0000, 16'd20000}) begin errors++; $display("FAIL inv_max got err=%b credit=%0d exp 0000 20000", error, credit); end
    insert(4'b0001);
    checks++; if ({error, coin_reject, credit} !== {4'b1000, 1'b1, 16'd20000}) begin errors++; $display("FAIL inv_limit got err=%b rej=%b credit=%0d exp 1000 1 20000", error, coin_reject, credit); end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    money_type = 4'b0001;
    cyc();
    money_type = 4'b0000;
    checks++; if ({coin_reject, error, change_type, credit} !== {1'b1, 4'b1000, 4'b1000, 16'd10000}) begin errors++; $display("FAIL inv_busy_coin got rej=%b err=%b type=%b credit=%0d exp 1 1000 1000 10000", coin_reject, error, change_type, credit); end
    cyc();
    cyc();
    cyc();
    checks++; if ({busy, change_valid, credit} !== 18'd0) begin errors++; $display("FAIL inv_drain got busy=%b cv=%b credit=%0d exp 0 0 0", busy, change_valid, credit); end
  endtask

  task automatic test_reset_mid_change();
    insert(4'b1000);
    insert(4'b1000);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    checks++; if ({change_valid, change_type, credit} !== {1'b1, 4'b1000, 16'd5000}) begin errors++; $display("FAIL rst_pre got cv=%b type=%b credit=%0d exp 1 1000 5000", change_valid, change_type, credit); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({change_valid, busy, credit} !== 18'd0) begin errors++; $display("FAIL rst_async got cv=%b busy=%b credit=%0d exp 0 0 0", change_valid, busy, credit); end
    cyc();
    reset = 1'b0;
    cyc();
    insert(4'b0100);
    insert(4'b0010);
    choose(2'd2);
    checks++; if ({dispense_valid, dispense_id} !== 3'b110) begin errors++; $display("FAIL rst_stock_restored got dv=%b id=%0d exp 1 2", dispense_valid, dispense_id); end
  endtask

  initial begin
    money_type   = 4'b0000;
    select_valid = 1'b0;
    product_sel  = 2'd0;
    cancel       = 1'b0;
    test_reset();
    test_basic_purchase();
    test_change_sequence();
    test_insufficient();
    test_out_of_stock();
    test_invalid_money();
    test_reset_mid_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Top-level sequencer for the vending machine.
- Accepts one-hot money events and accumulates credit. Arbitrates product selection against price and per-product stock.
- Issues a one-cycle dispense pulse, then pays change one coin per cycle using greedy denominations.
- Sits between the front-panel inputs and the dispense/change actuators.

Parameters:
- PRICE0, 1500, price of product 0 (multiple of 500)
- PRICE1, 2500, price of product 1 (multiple of 500)
- PRICE2, 3000, price of product 2 (multiple of 500)
- PRICE3, 6000, price of product 3 (multiple of 500)
- STOCK_INIT, 8'd5, initial stock of every product after reset
- MAX_CREDIT, 16'd20000, highest credit accepted

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately
- money_type  in  4  0001=500, 0010=1000, 0100=2000, 1000=5000; 0000=no event; any other value is invalid
- select_valid  in  1  product selection strobe
- product_sel  in  2  product index, sampled with select_valid
- cancel  in  1  refund request
- credit  out  16  current credit
- busy  out  1  high in DISPENSE and CHANGE states
- dispense_valid  out  1  one-cycle pulse
- dispense_id  out  2  product being dispensed, valid with dispense_valid
- change_valid  out  1  one coin returned this cycle
- change_type  out  4  denomination of the returned coin, same one-hot coding as money_type
- coin_reject  out  1  one-cycle pulse; the inserted coin is refused
- error  out  4  0001 invalid money, 0010 insufficient credit, 0100 out of stock, 1000 credit limit

Behaviour:
- Reset values:
  - State IDLE; credit 0; error 0.
  - All pulse outputs 0; change_type 0; dispense_id 0.
  - Stock for every product = STOCK_INIT.
- All outputs are registered. Effects appear on the edge after the sampled input.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- Input priority in IDLE/COLLECT within one cycle: cancel > select_valid > money_type.
  - A valid coin arriving in the same cycle as cancel or select_valid is refused: coin_reject=1, credit unchanged.
- Coin handling (IDLE/COLLECT only):
  - Valid one-hot coin with credit+value <= MAX_CREDIT: credit += value, error cleared, state -> COLLECT.
  - Valid coin that would exceed MAX_CREDIT: coin_reject=1, error=1000.
  - money_type outside {0000, one-hot}: error=0001, coin_reject=1.
  - In DISPENSE/CHANGE, any nonzero money_type gives coin_reject=1. No error is raised there.
- Selection (IDLE/COLLECT):
  - Stock of product_sel is 0: error=0100, stay in current state.
  - Otherwise, if credit < price: error=0010, stay.
  - Otherwise: credit -= price, that stock decrements by 1, error cleared, -> DISPENSE.
  - The stock test takes precedence over the credit test.
- DISPENSE (one cycle):
  - dispense_valid=1 and dispense_id=product.
  - Next state CHANGE if credit != 0, else IDLE.
- Cancel:
  - In COLLECT with credit != 0: -> CHANGE.
  - In IDLE, or with credit 0: ignored.
  - Ignored in DISPENSE/CHANGE.
- CHANGE:
  - Each cycle emits the largest denomination <= credit (5000 > 2000 > 1000 > 500): change_valid=1, change_type set, credit -= value.
  - Go to IDLE on the cycle credit reaches 0. change_valid is low in IDLE.
  - select_valid is ignored in CHANGE.
- Credit is always a multiple of 500, so change always terminates exactly.
- error is sticky. It is overwritten by a new error, and cleared by an accepted coin or a successful selection.
- Stock saturates at 0 and never wraps. Credit arithmetic is 16-bit and never overflows, because of the MAX_CREDIT check.
- Reset during DISPENSE or CHANGE aborts immediately. Remaining change is forfeited and stock is restored to STOCK_INIT.

Test Plan:
- Coins 1000 then 1000, then select product 0:
  - credit reads 1000 then 2000.
  - dispense_valid with id 0 one cycle after select.
  - Next cycle: change 0001 (500); then IDLE with credit 0.
- Coins 5000 + 2000, then select product 1 (2500):
  - Change sequence 2000, 2000, 500 on consecutive cycles; busy high throughout.
- Coin 500, then select product 3:
  - error=0010, credit stays 500, no dispense.
  - Then cancel -> change_type 0001 once, then IDLE.
- Buy product 2 five times from exact credit, then a sixth attempt with 3000 credit:
  - error=0100 on the sixth attempt, credit stays 3000.
- money_type=0011:
  - error=0001 and coin_reject.
  - A coin in the same cycle as select_valid gives coin_reject with credit unchanged.
  - Four 5000 coins then a 500 coin: the fifth coin gives coin_reject with error=1000.
- Reset asserted mid-CHANGE:
  - credit=0, change_valid=0, state IDLE immediately, without waiting for the next clock edge.
